// File: rtl/mem_arb_if.sv
// Bus bundle for the memory arbiter: fetch port, LSU port, memory port and busy flag.
// The arbiter uses the slave view; the CPU/memory side uses the master view.
interface mem_arb_if #(
  parameter int XLEN = 32
);
  logic            if_req_i;
  logic [XLEN-1:0] if_adr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [XLEN-1:0] if_rdata_o;

  logic            lsu_req_i;
  logic [XLEN-1:0] lsu_adr_i;
  logic            lsu_we_i;
  logic [XLEN-1:0] lsu_wdata_i;
  logic [2:0]      lsu_size_i;
  logic            lsu_gnt_o;
  logic            lsu_rvalid_o;
  logic [XLEN-1:0] lsu_rdata_o;

  logic            mem_req_o;
  logic [XLEN-1:0] mem_adr_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [2:0]      mem_size_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  logic            busy_o;

  modport slave (
    input  if_req_i, if_adr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_req_i, lsu_adr_i, lsu_we_i, lsu_wdata_i, lsu_size_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_adr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_req_i, lsu_adr_i, lsu_we_i, lsu_wdata_i, lsu_size_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_arb.sv
// Fetch/LSU arbiter in front of a single-port memory: one transaction in flight,
// LSU priority with a bounded starvation window for fetch.
module mem_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input logic      clk,
  input logic      reset_n,
  mem_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       OWN_IF     = 1'b0;
  localparam logic       OWN_LSU    = 1'b1;

  state_t          state_reg, state_next;
  logic            owner_reg, owner_next;
  logic [3:0]      starve_reg, starve_next;
  logic [XLEN-1:0] adr_reg, adr_next;
  logic            we_reg, we_next;
  logic [XLEN-1:0] wdata_reg, wdata_next;
  logic [2:0]      size_reg, size_next;

  logic grant_lsu;
  logic grant_if;

  // Fetch overrides LSU priority only once its wait has hit the limit.
  assign grant_lsu = bus.lsu_req_i && !(bus.if_req_i && (starve_reg == STARVE_LIM));
  assign grant_if  = bus.if_req_i && !grant_lsu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      owner_reg  <= OWN_IF;
      starve_reg <= 4'd0;
      adr_reg    <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      size_reg   <= 3'd0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      starve_reg <= starve_next;
      adr_reg    <= adr_next;
      we_reg     <= we_next;
      wdata_reg  <= wdata_next;
      size_reg   <= size_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    starve_next      = starve_reg;
    adr_next         = adr_reg;
    we_next          = we_reg;
    wdata_next       = wdata_reg;
    size_next        = size_reg;
    bus.if_gnt_o     = 1'b0;
    bus.if_rvalid_o  = 1'b0;
    bus.if_rdata_o   = '0;
    bus.lsu_gnt_o    = 1'b0;
    bus.lsu_rvalid_o = 1'b0;
    bus.lsu_rdata_o  = '0;
    bus.mem_req_o    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (grant_lsu) begin
          bus.lsu_gnt_o = 1'b1;
          owner_next    = OWN_LSU;
          adr_next      = bus.lsu_adr_i;
          we_next       = bus.lsu_we_i;
          wdata_next    = bus.lsu_wdata_i;
          size_next     = bus.lsu_size_i;
          if (!bus.if_req_i)
            starve_next = 4'd0;
          else if (starve_reg != STARVE_LIM)
            starve_next = starve_reg + 4'd1;
          state_next    = REQ;
        end else if (grant_if) begin
          bus.if_gnt_o = 1'b1;
          owner_next   = OWN_IF;
          adr_next     = bus.if_adr_i;
          we_next      = 1'b0;
          wdata_next   = '0;
          size_next    = 3'b010;
          starve_next  = 4'd0;
          state_next   = REQ;
        end
      end
      REQ: begin
        bus.mem_req_o = 1'b1;
        if (bus.mem_gnt_i)
          state_next = RSP;
      end
      RSP: begin
        if (bus.mem_rvalid_i) begin
          if (owner_reg == OWN_LSU) begin
            bus.lsu_rvalid_o = 1'b1;
            bus.lsu_rdata_o  = we_reg ? '0 : bus.mem_rdata_i;
          end else begin
            bus.if_rvalid_o = 1'b1;
            bus.if_rdata_o  = bus.mem_rdata_i;
          end
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_adr_o   = adr_reg;
  assign bus.mem_we_o    = we_reg;
  assign bus.mem_wdata_o = wdata_reg;
  assign bus.mem_size_o  = size_reg;
  assign bus.busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Randomized bench for mem_arb: the bench plays fetch unit, LSU and memory, and checks
// every cycle against a transaction-level model of the arbitration and response rules.
module tb_mem_arb;
  localparam int XLEN = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if #(.XLEN(XLEN)) bus ();

  mem_arb #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.if_req_i     = 1'b0;
    bus.if_adr_i     = '0;
    bus.lsu_req_i    = 1'b0;
    bus.lsu_adr_i    = '0;
    bus.lsu_we_i     = 1'b0;
    bus.lsu_wdata_i  = '0;
    bus.lsu_size_i   = 3'd0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_if_gnt"},     32'(bus.if_gnt_o),     32'd0);
    chk({pfx, "_if_rvalid"},  32'(bus.if_rvalid_o),  32'd0);
    chk({pfx, "_if_rdata"},   bus.if_rdata_o,        32'd0);
    chk({pfx, "_lsu_gnt"},    32'(bus.lsu_gnt_o),    32'd0);
    chk({pfx, "_lsu_rvalid"}, 32'(bus.lsu_rvalid_o), 32'd0);
    chk({pfx, "_lsu_rdata"},  bus.lsu_rdata_o,       32'd0);
    chk({pfx, "_mem_req"},    32'(bus.mem_req_o),    32'd0);
    chk({pfx, "_mem_adr"},    bus.mem_adr_o,         32'd0);
    chk({pfx, "_mem_we"},     32'(bus.mem_we_o),     32'd0);
    chk({pfx, "_mem_wdata"},  bus.mem_wdata_o,       32'd0);
    chk({pfx, "_mem_size"},   32'(bus.mem_size_o),   32'd0);
    chk({pfx, "_busy"},       32'(bus.busy_o),       32'd0);
  endtask

  // Transaction-level model state
  bit          f_pend, l_pend, l_we;
  logic [31:0] f_adr, l_adr, l_wdata;
  logic [2:0]  l_size;
  bit          outst, own_lsu;
  int          phase;          // 0: nothing at memory, 1: awaiting mem grant, 2: awaiting response
  int          streak;         // LSU grants in a row while fetch was waiting
  logic [31:0] t_adr, t_wdata;
  bit          t_we;
  logic [2:0]  t_size;
  logic [31:0] mem_arr [16];

  initial begin
    bit win_l, win_f, e_if_gnt, e_l_gnt, rsp;
    logic [31:0] e_data;
    int pct;

    drive_idle();
    for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;

    // Outputs under reset
    repeat (3) @(posedge clk);
    #1 chk_all_zero("rst");
    @(negedge clk) reset_n = 1'b1;

    // Directed fetch read with fixed latencies
    @(posedge clk); #1 bus.if_req_i = 1'b1; bus.if_adr_i = 32'h100;
    @(negedge clk);
    chk("d_if_gnt", 32'(bus.if_gnt_o), 32'd1);
    chk("d_busy_c0", 32'(bus.busy_o), 32'd0);
    @(posedge clk); #1 bus.if_req_i = 1'b0; bus.if_adr_i = 32'hFFF0; bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("d_mem_req", 32'(bus.mem_req_o), 32'd1);
    chk("d_mem_adr", bus.mem_adr_o, 32'h100);
    chk("d_mem_size", 32'(bus.mem_size_o), 32'd2);
    chk("d_if_gnt_c1", 32'(bus.if_gnt_o), 32'd0);
    @(posedge clk); #1 bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("d_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
    chk("d_if_rdata", bus.if_rdata_o, 32'hDEADBEEF);
    chk("d_lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'd0);
    @(posedge clk); #1 bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    @(negedge clk);
    chk("d_busy_c3", 32'(bus.busy_o), 32'd0);

    // Reset while waiting for the response, then a late mem_rvalid_i
    @(posedge clk); #1 bus.lsu_req_i = 1'b1; bus.lsu_adr_i = 32'h300;
    @(negedge clk);
    chk("r_lsu_gnt", 32'(bus.lsu_gnt_o), 32'd1);
    @(posedge clk); #1 bus.lsu_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    @(posedge clk); #1 bus.mem_gnt_i = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk_all_zero("rsp_rst");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1 bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h12345678;
    @(negedge clk);
    chk("r_lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'd0);
    chk("r_lsu_rdata", bus.lsu_rdata_o, 32'd0);
    chk("r_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk); #1 bus.mem_rvalid_i = 1'b0;

    // Randomized traffic against the model
    f_pend = 0; l_pend = 0; outst = 0; own_lsu = 0; phase = 0; streak = 0;
    for (int seg = 0; seg < 4; seg++) begin
      pct = (seg == 0) ? 20 : (seg == 1) ? 60 : (seg == 2) ? 90 : 100;
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(posedge clk); #1;
        if (!f_pend && $urandom_range(0, 99) < pct) begin
          f_pend = 1;
          f_adr  = {$urandom} & 32'hFFFF_FFFC;
        end
        if (!l_pend && $urandom_range(0, 99) < pct) begin
          l_pend  = 1;
          l_adr   = {$urandom} & 32'hFFFF_FFFC;
          l_we    = 1'($urandom_range(0, 1));
          l_wdata = $urandom;
          l_size  = 3'($urandom_range(0, 7));
        end
        bus.if_req_i    = f_pend;
        bus.if_adr_i    = f_pend ? f_adr : $urandom;
        bus.lsu_req_i   = l_pend;
        bus.lsu_adr_i   = l_pend ? l_adr : $urandom;
        bus.lsu_we_i    = l_pend ? l_we : 1'($urandom_range(0, 1));
        bus.lsu_wdata_i = l_pend ? l_wdata : $urandom;
        bus.lsu_size_i  = l_pend ? l_size : 3'($urandom_range(0, 7));
        bus.mem_gnt_i    = (phase == 1) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 10);
        bus.mem_rvalid_i = (phase == 2) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 10);
        bus.mem_rdata_i  = (phase == 2 && !t_we) ? mem_arr[bus.mem_adr_o[5:2]] : $urandom;

        @(negedge clk);
        win_l    = l_pend && !(f_pend && streak >= SMAX);
        win_f    = f_pend && !win_l;
        e_if_gnt = !outst && win_f;
        e_l_gnt  = !outst && win_l;
        rsp      = (phase == 2) && bus.mem_rvalid_i;
        e_data   = mem_arr[t_adr[5:2]];

        chk("if_gnt", 32'(bus.if_gnt_o), 32'(e_if_gnt));
        chk("lsu_gnt", 32'(bus.lsu_gnt_o), 32'(e_l_gnt));
        chk("busy", 32'(bus.busy_o), 32'(outst));
        chk("mem_req", 32'(bus.mem_req_o), 32'(phase == 1));
        if (phase == 1) begin
          chk("mem_adr", bus.mem_adr_o, t_adr);
          chk("mem_we", 32'(bus.mem_we_o), 32'(t_we));
          chk("mem_wdata", bus.mem_wdata_o, t_wdata);
          chk("mem_size", 32'(bus.mem_size_o), 32'(t_size));
        end
        chk("if_rvalid", 32'(bus.if_rvalid_o), 32'(rsp && !own_lsu));
        chk("if_rdata", bus.if_rdata_o, (rsp && !own_lsu) ? e_data : 32'd0);
        chk("lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'(rsp && own_lsu));
        chk("lsu_rdata", bus.lsu_rdata_o, (rsp && own_lsu && !t_we) ? e_data : 32'd0);

        if (rsp) begin
          $display("txn %s adr=%h we=%0d data=%h", own_lsu ? "lsu" : "if ", t_adr, t_we,
                   t_we ? t_wdata : e_data);
          if (own_lsu && t_we) mem_arr[t_adr[5:2]] = t_wdata;
          outst = 0;
          phase = 0;
        end else if (phase == 1 && bus.mem_gnt_i) begin
          phase = 2;
        end
        if (e_if_gnt) begin
          outst = 1; phase = 1; own_lsu = 0;
          t_adr = f_adr; t_we = 0; t_wdata = '0; t_size = 3'b010;
          streak = 0;
          f_pend = 0;
        end else if (e_l_gnt) begin
          outst = 1; phase = 1; own_lsu = 1;
          t_adr = l_adr; t_we = l_we; t_wdata = l_wdata; t_size = l_size;
          streak = f_pend ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
          l_pend = 0;
        end
      end
    end

    drive_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: XLEN, 32, data/address width.
REQ-002 Parameter: STARVE_MAX, 4, max consecutive LSU grants while fetch is waiting before fetch is forced to win (range 1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req_i  input  1  fetch read request, held until if_gnt_o.
REQ-006 if_adr_i  input  XLEN  fetch address.
REQ-007 if_gnt_o  output  1  one-cycle pulse: fetch request captured.
REQ-008 if_rvalid_o  output  1  fetch read data valid.
REQ-009 if_rdata_o  output  XLEN  fetch read data; zero when if_rvalid_o low.
REQ-010 lsu_req_i  input  1  load/store request (driven from execute adr_v), held until lsu_gnt_o.
REQ-011 lsu_adr_i  input  XLEN  LSU address.
REQ-012 lsu_we_i  input  1  1 = store, 0 = load.
REQ-013 lsu_wdata_i  input  XLEN  store data.
REQ-014 lsu_size_i  input  3  access size code, passed through unchanged.
REQ-015 lsu_gnt_o  output  1  one-cycle pulse: LSU request captured.
REQ-016 lsu_rvalid_o  output  1  LSU completion; load data valid, or store acknowledged.
REQ-017 lsu_rdata_o  output  XLEN  load data; zero when lsu_rvalid_o low or on store completion.
REQ-018 mem_req_o  output  1  request to single-port memory.
REQ-019 mem_adr_o / mem_we_o / mem_wdata_o / mem_size_o  output  XLEN/1/XLEN/3  latched request fields.
REQ-020 mem_gnt_i  input  1  memory accepted the request.
REQ-021 mem_rvalid_i  input  1  memory completion.
REQ-022 mem_rdata_i  input  XLEN  memory read data.
REQ-023 busy_o  output  1  high in any state other than IDLE.

Function
REQ-024 FSM states: IDLE, REQ, RSP; at most one transaction outstanding.
REQ-025 IDLE: if any request is pending, the winner is selected, its fields are latched, its gnt_o pulses in that same cycle, owner is recorded, and the FSM moves to REQ; otherwise it stays in IDLE.
REQ-026 Fetch requests latch mem_we=0, mem_wdata=0, mem_size=3'b010.
REQ-027 Arbitration: LSU wins when both request, unless starve_cnt == STARVE_MAX, in which case fetch wins; a single requester always wins.
REQ-028 starve_cnt: increments (saturating at STARVE_MAX) on an LSU grant with if_req_i high; clears on a fetch grant or on an LSU grant with if_req_i low.
REQ-029 REQ: mem_req_o=1 with the latched fields held stable; on mem_gnt_i go to RSP; remain in REQ indefinitely otherwise.
REQ-030 RSP: mem_req_o=0; on mem_rvalid_i assert the owner's rvalid_o combinationally in the same cycle, route mem_rdata_i to the owner (loads/fetch only), and return to IDLE.
REQ-031 Arbitration for the next transaction occurs in IDLE, at the earliest the cycle after completion; best-case occupancy is 3 cycles per access (capture, mem grant, response).
REQ-032 mem_gnt_i outside REQ and mem_rvalid_i outside RSP are ignored: no state change, no rvalid_o.
REQ-033 Requests raised while busy_o=1 are not granted until IDLE; gnt_o never pulses outside IDLE.
REQ-034 The non-owner's rvalid_o is 0 and its rdata_o is 0 at all times.
REQ-035 Request inputs are sampled only in IDLE; changes at other times have no effect on the latched transaction.

Reset
REQ-036 Asserting reset_n low forces IDLE, starve_cnt=0, owner=fetch, and all latched fields to 0, asynchronously, including mid-transaction.
REQ-037 During and after reset, all outputs are 0 until the first grant: gnt, rvalid, rdata, mem_req_o, mem_* fields, busy_o.
REQ-038 A mem_rvalid_i arriving after a mid-transaction reset is ignored (per REQ-032).

Verification
REQ-039 Fetch-only read: if_req_i=1, if_adr_i=0x100; mem_gnt_i on the next cycle; mem_rvalid_i with rdata 0xDEADBEEF one cycle later -> if_gnt_o pulses in cycle 0, mem_req_o=1 with mem_adr_o=0x100 in cycle 1, if_rvalid_o=1 with if_rdata_o=0xDEADBEEF in cycle 2, busy_o low in cycle 3.
REQ-040 Simultaneous requests: LSU store 0x200/0x55 and fetch 0x104 -> LSU granted first (mem_we_o=1, mem_wdata_o=0x55), lsu_rvalid_o=1 with lsu_rdata_o=0; fetch granted at the next IDLE.
REQ-041 Starvation: LSU and fetch requesting continuously, STARVE_MAX=4 -> grant order is LSU x4 then fetch, repeating; starve_cnt returns to 0 after each fetch grant.
REQ-042 Memory stall: mem_gnt_i held low 10 cycles in REQ with inputs changing -> mem_* outputs remain stable and no gnt_o pulse occurs.
REQ-043 Reset in RSP: reset_n pulsed low, then mem_rvalid_i=1 -> no rvalid_o; FSM in IDLE; all outputs 0.
REQ-044 Spurious mem_rvalid_i in IDLE and spurious mem_gnt_i in RSP -> no state change and no rvalid_o.
